// File: rtl/billiard_pkg.sv
// Shared billiard types and constants: index widths, transparency code,
// arbiter FSM states and the event payload.
package billiard_pkg;

    localparam int unsigned NUM_BALLS_MAX   = 16;
    localparam int unsigned NUM_POCKETS_MAX = 8;
    localparam int unsigned BALL_IDX_W      = 4;
    localparam int unsigned POCKET_IDX_W    = 3;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PICK    = 2'd1,
        PRESENT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [BALL_IDX_W-1:0]   ball;
        logic [POCKET_IDX_W-1:0] pocket;
    } pocket_event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant,
// wrapping at NUM_BALLS.
module rr_arbiter
    import billiard_pkg::*;
#(
    parameter int unsigned NUM_BALLS = 16
) (
    input  logic [NUM_BALLS-1:0]  req,
    input  logic [BALL_IDX_W-1:0] last_grant,
    output logic [BALL_IDX_W-1:0] grant_idx,
    output logic                  grant_valid
);

    int unsigned           idx;
    logic [BALL_IDX_W-1:0] idx_w;

    // Scan farthest offset first so the nearest requester overwrites the result.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int unsigned off = NUM_BALLS; off != 0; off--) begin
            idx = 32'(last_grant) + off;
            if (idx >= NUM_BALLS) begin
                idx = idx - NUM_BALLS;
            end
            idx_w = BALL_IDX_W'(idx);
            if (req[idx_w]) begin
                grant_idx   = idx_w;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pocket_event_arbiter.sv
// Captures ball/pocket overlaps per frame, queues them at the frame boundary and
// hands them to game logic one event at a time in round-robin order.
module pocket_event_arbiter
    import billiard_pkg::*;
#(
    parameter int unsigned NUM_BALLS   = 16,
    parameter int unsigned NUM_POCKETS = 6
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    newGame,
    input  logic [NUM_POCKETS-1:0]  drawingRequestHole,
    input  logic [NUM_BALLS-1:0]    drawingRequestBall,
    input  logic                    event_ready,
    output logic                    event_valid,
    output logic [BALL_IDX_W-1:0]   event_ball,
    output logic [POCKET_IDX_W-1:0] event_pocket,
    output logic [NUM_BALLS-1:0]    pocketed_mask
);

    localparam logic [BALL_IDX_W-1:0] LAST_GRANT_RST = BALL_IDX_W'(NUM_BALLS - 1);

    arb_state_t state_q, state_d;

    logic [NUM_BALLS-1:0]                   pending_q, pending_d;
    logic [NUM_BALLS-1:0]                   queue_q, queue_d;
    logic [NUM_BALLS-1:0]                   mask_q, mask_d;
    logic [NUM_BALLS-1:0][POCKET_IDX_W-1:0] pend_pocket_q, pend_pocket_d;
    logic [NUM_BALLS-1:0][POCKET_IDX_W-1:0] queue_pocket_q, queue_pocket_d;
    logic [BALL_IDX_W-1:0]                  last_grant_q, last_grant_d;
    logic                                   valid_q, valid_d;
    pocket_event_t                          event_q, event_d;

    logic [POCKET_IDX_W-1:0] hole_idx_c;
    logic                    hole_any_c;
    logic [NUM_BALLS-1:0]    hit_c;
    logic [NUM_BALLS-1:0]    sof_pending_c;
    logic                    handshake_c;
    logic [BALL_IDX_W-1:0]   grant_idx_c;
    logic                    grant_valid_c;

    rr_arbiter #(
        .NUM_BALLS (NUM_BALLS)
    ) u_rr_arbiter (
        .req         (queue_q),
        .last_grant  (last_grant_q),
        .grant_idx   (grant_idx_c),
        .grant_valid (grant_valid_c)
    );

    // Lowest asserted hole wins when several overlap the same pixel.
    always_comb begin
        hole_idx_c = '0;
        for (int i = int'(NUM_POCKETS) - 1; i >= 0; i--) begin
            if (drawingRequestHole[i]) begin
                hole_idx_c = POCKET_IDX_W'(i);
            end
        end
    end

    // Balls moving into the queue this cycle must not re-arm pending.
    assign hole_any_c    = |drawingRequestHole;
    assign sof_pending_c = startOfFrame ? pending_q : '0;
    assign hit_c         = drawingRequestBall & {NUM_BALLS{hole_any_c}}
                         & ~mask_q & ~queue_q & ~sof_pending_c;
    assign handshake_c   = (state_q == PRESENT) && event_ready;

    always_comb begin
        pending_d      = startOfFrame ? hit_c : (pending_q | hit_c);
        pend_pocket_d  = pend_pocket_q;
        queue_pocket_d = queue_pocket_q;
        for (int b = 0; b < int'(NUM_BALLS); b++) begin
            if (hit_c[b] && (startOfFrame || !pending_q[b])) begin
                pend_pocket_d[b] = hole_idx_c;
            end
            if (sof_pending_c[b]) begin
                queue_pocket_d[b] = pend_pocket_q[b];
            end
        end
        if (newGame) begin
            pending_d = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        event_d      = event_q;
        mask_d       = mask_q;
        last_grant_d = last_grant_q;
        queue_d      = queue_q;
        if (handshake_c) begin
            queue_d[event_q.ball] = 1'b0;
        end
        queue_d = queue_d | sof_pending_c;

        case (state_q)
            IDLE: begin
                if (queue_q != '0) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                if (grant_valid_c) begin
                    valid_d        = 1'b1;
                    event_d.ball   = grant_idx_c;
                    event_d.pocket = queue_pocket_q[grant_idx_c];
                    state_d        = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (event_ready) begin
                    valid_d              = 1'b0;
                    mask_d[event_q.ball] = 1'b1;
                    last_grant_d         = event_q.ball;
                    state_d              = (queue_d != '0) ? PICK : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (newGame) begin
            state_d      = IDLE;
            valid_d      = 1'b0;
            event_d      = '0;
            mask_d       = '0;
            last_grant_d = LAST_GRANT_RST;
            queue_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending_q      <= '0;
            queue_q        <= '0;
            mask_q         <= '0;
            pend_pocket_q  <= '0;
            queue_pocket_q <= '0;
            last_grant_q   <= LAST_GRANT_RST;
            valid_q        <= 1'b0;
            event_q        <= '0;
        end else begin
            pending_q      <= pending_d;
            queue_q        <= queue_d;
            mask_q         <= mask_d;
            pend_pocket_q  <= pend_pocket_d;
            queue_pocket_q <= queue_pocket_d;
            last_grant_q   <= last_grant_d;
            valid_q        <= valid_d;
            event_q        <= event_d;
        end
    end

    assign event_valid   = valid_q;
    assign event_ball    = event_q.ball;
    assign event_pocket  = event_q.pocket;
    assign pocketed_mask = mask_q;

endmodule
